// File: rtl/clock_pkg.sv
// Shared constants and BCD helper for the 24-hour timekeeping core.
// Limits are packed BCD: [7:4] tens digit, [3:0] units digit.
package clock_pkg;

   localparam logic [7:0] SEC_MAX_BCD = 8'h59;
   localparam logic [7:0] MIN_MAX_BCD = 8'h59;
   localparam logic [7:0] HR_MAX_BCD  = 8'h23;
   localparam logic [7:0] BCD_ZERO    = 8'h00;

   // Two-digit BCD +1; units 9 -> 0 carries into tens.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      logic [3:0] tens;
      logic [3:0] units;
      tens  = v[7:4];
      units = v[3:0];
      if (units == 4'd9) begin
         tens  = tens + 4'd1;
         units = 4'd0;
      end else begin
         units = units + 4'd1;
      end
      return {tens, units};
   endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps from MAX_BCD to 00.
// wrap flags the increment that takes it back to zero.
module bcd_mod_counter
   import clock_pkg::*;
#(
   parameter logic [7:0] MAX_BCD = 8'h59
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       inc,
   output logic [7:0] value,
   output logic       wrap
);

   logic at_max;

   // Terminal value detect, shared by wrap and the update.
   assign at_max = (value == MAX_BCD);
   assign wrap   = inc & at_max;

   // Clear wins over increment; increment at max returns to zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value <= BCD_ZERO;
      end else if (clr) begin
         value <= BCD_ZERO;
      end else if (inc) begin
         value <= at_max ? BCD_ZERO : bcd_inc(value);
      end
   end

endmodule

// File: rtl/time_counter.sv
// 24-hour hh:mm:ss core driven by a synchronised 1 Hz edge,
// with a set mode for manual hour/minute adjustment.
module time_counter
   import clock_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clk_1Hz_in,
   input  logic       set_mode,
   input  logic       inc_hr,
   input  logic       inc_min,
   output logic [7:0] sec_bcd,
   output logic [7:0] min_bcd,
   output logic [7:0] hr_bcd,
   output logic       sec_tick
);

   if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("SYNC_STAGES must be 2..4");
   end

   logic [SYNC_STAGES-1:0] sync;
   logic [SYNC_STAGES-1:0] prime;
   logic                   s;
   logic                   s_d;
   logic                   armed;
   logic                   rise;

   logic sec_inc;
   logic min_inc;
   logic hr_inc;
   logic sec_wrap;
   logic min_wrap;
   logic hr_wrap;

   assign s    = sync[SYNC_STAGES-1];
   assign rise = armed & s & ~s_d;

   // Synchroniser chain plus a parallel fill marker: the reset-zero
   // in the chain is not a real sample, so arming waits until the
   // marker reaches the last stage and s reflects the actual input.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync  <= '0;
         prime <= '0;
         s_d   <= 1'b0;
         armed <= 1'b0;
      end else begin
         sync  <= {sync[SYNC_STAGES-2:0], clk_1Hz_in};
         prime <= {prime[SYNC_STAGES-2:0], 1'b1};
         s_d   <= s;
         armed <= armed | (prime[SYNC_STAGES-1] & ~s);
      end
   end

   // Increment routing: carry chain in run mode, manual pulses in set mode.
   always_comb begin
      sec_inc = 1'b0;
      min_inc = 1'b0;
      hr_inc  = 1'b0;
      unique case (1'b1)
         set_mode: begin
            min_inc = inc_min;
            hr_inc  = inc_hr;
         end
         default: begin
            sec_inc = rise;
            min_inc = sec_wrap;
            hr_inc  = min_wrap;
         end
      endcase
   end

   // Tick marks the cycle the new seconds value is first visible.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sec_tick <= 1'b0;
      end else begin
         sec_tick <= sec_inc;
      end
   end

   bcd_mod_counter #(.MAX_BCD(SEC_MAX_BCD)) u_sec (
      .clk   (clk),
      .rst   (rst),
      .clr   (set_mode),
      .inc   (sec_inc),
      .value (sec_bcd),
      .wrap  (sec_wrap)
   );

   bcd_mod_counter #(.MAX_BCD(MIN_MAX_BCD)) u_min (
      .clk   (clk),
      .rst   (rst),
      .clr   (1'b0),
      .inc   (min_inc),
      .value (min_bcd),
      .wrap  (min_wrap)
   );

   bcd_mod_counter #(.MAX_BCD(HR_MAX_BCD)) u_hr (
      .clk   (clk),
      .rst   (rst),
      .clr   (1'b0),
      .inc   (hr_inc),
      .value (hr_bcd),
      .wrap  (hr_wrap)
   );

   logic unused_hr_wrap;
   assign unused_hr_wrap = hr_wrap;

endmodule

// File: tb/tb_time_counter.sv
// Directed bench for time_counter: counting, arming, set mode,
// rollover and asynchronous reset, checked against hand values.
module tb_time_counter;

   logic       clk;
   logic       rst;
   logic       clk_1Hz_in;
   logic       set_mode;
   logic       inc_hr;
   logic       inc_min;
   logic [7:0] sec_bcd;
   logic [7:0] min_bcd;
   logic [7:0] hr_bcd;
   logic       sec_tick;

   int n_checks  = 0;
   int n_fail    = 0;
   int tick_total;
   int bad_lat;
   int bad_width;
   logic [23:0] pre_tick;
   logic [23:0] at_tick;

   time_counter #(.SYNC_STAGES(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .clk_1Hz_in (clk_1Hz_in),
      .set_mode   (set_mode),
      .inc_hr     (inc_hr),
      .inc_min    (inc_min),
      .sec_bcd    (sec_bcd),
      .min_bcd    (min_bcd),
      .hr_bcd     (hr_bcd),
      .sec_tick   (sec_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [23:0] now();
      return {hr_bcd, min_bcd, sec_bcd};
   endfunction

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Hold rst for three cycles with the 1 Hz input at lvl.
   task automatic do_reset(input logic lvl);
      rst        = 1'b1;
      clk_1Hz_in = lvl;
      set_mode   = 1'b0;
      inc_hr     = 1'b0;
      inc_min    = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   // One 1 Hz period: 6 cycles high, 6 low. Counts ticks, their
   // latency from the rising edge and the value around the tick.
   task automatic edge_1hz(input bit want_tick);
      int n;
      int lat;
      logic [23:0] prev;
      n   = 0;
      lat = 0;
      prev = now();
      clk_1Hz_in = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         if (i == 7) clk_1Hz_in = 1'b0;
         @(negedge clk);
         if (sec_tick) begin
            n++;
            if (lat == 0) begin
               lat      = i;
               pre_tick = prev;
               at_tick  = now();
            end
         end
         prev = now();
      end
      tick_total += n;
      if (want_tick) begin
         if (n != 1) bad_width++;
         if (lat < 2 || lat > 4) bad_lat++;
      end
   endtask

   task automatic hold_hr(input int n);
      inc_hr = 1'b1;
      repeat (n) @(negedge clk);
      inc_hr = 1'b0;
   endtask

   task automatic hold_min(input int n);
      inc_min = 1'b1;
      repeat (n) @(negedge clk);
      inc_min = 1'b0;
   endtask

   initial begin
      tick_total = 0;
      bad_lat    = 0;
      bad_width  = 0;

      // Reset with input low, then 60 edges
      rst = 1'b1;
      clk_1Hz_in = 1'b0;
      set_mode = 1'b0;
      inc_hr = 1'b0;
      inc_min = 1'b0;
      @(negedge clk);
      check("reset_time", {8'h0, now()}, 32'h000000);
      check("reset_tick", {31'h0, sec_tick}, 32'h0);
      do_reset(1'b0);
      repeat (4) @(negedge clk);
      repeat (60) edge_1hz(1'b1);
      check("run60_time", {8'h0, now()}, 32'h000100);
      check("run60_ticks", tick_total, 60);
      check("run60_latency", bad_lat, 0);
      check("run60_width", bad_width, 0);

      // Reset released while input is high
      do_reset(1'b1);
      tick_total = 0;
      repeat (12) @(negedge clk);
      check("hi_rel_ticks", tick_total + sec_tick, 0);
      check("hi_rel_time", {8'h0, now()}, 32'h000000);
      clk_1Hz_in = 1'b0;
      repeat (6) @(negedge clk);
      check("hi_rel_quiet", {8'h0, now()}, 32'h000000);
      edge_1hz(1'b1);
      check("hi_rel_first", {8'h0, now()}, 32'h000001);

      // Set to 23:59, run to full rollover
      do_reset(1'b0);
      repeat (4) @(negedge clk);
      set_mode = 1'b1;
      hold_hr(23);
      hold_min(59);
      check("set_2359", {8'h0, now()}, 32'h235900);
      set_mode = 1'b0;
      @(negedge clk);
      tick_total = 0;
      repeat (59) edge_1hz(1'b1);
      check("run_235959", {8'h0, now()}, 32'h235959);
      check("run_ticks59", tick_total, 59);
      edge_1hz(1'b1);
      check("roll_pre", {8'h0, pre_tick}, 32'h235959);
      check("roll_at", {8'h0, at_tick}, 32'h000000);
      check("roll_after", {8'h0, now()}, 32'h000000);

      // Set mode: clear, discard ticks, dual inc, minute wrap
      repeat (2) edge_1hz(1'b1);
      check("run_2s", {8'h0, now()}, 32'h000002);
      set_mode = 1'b1;
      @(negedge clk);
      check("set_clr_sec", {24'h0, sec_bcd}, 32'h00);
      hold_hr(5);
      hold_min(10);
      tick_total = 0;
      repeat (3) edge_1hz(1'b0);
      inc_hr  = 1'b1;
      inc_min = 1'b1;
      @(negedge clk);
      inc_hr  = 1'b0;
      inc_min = 1'b0;
      check("set_dual", {8'h0, now()}, 32'h061100);
      check("set_ticks", tick_total, 0);
      hold_min(48);
      check("set_0659", {8'h0, now()}, 32'h065900);
      hold_min(1);
      check("set_minwrap", {8'h0, now()}, 32'h060000);
      set_mode = 1'b0;
      @(negedge clk);
      edge_1hz(1'b1);
      check("resume", {8'h0, now()}, 32'h060001);

      // Run mode ignores manual pulses
      inc_hr  = 1'b1;
      inc_min = 1'b1;
      @(negedge clk);
      inc_hr  = 1'b0;
      inc_min = 1'b0;
      repeat (2) @(negedge clk);
      check("run_ign_inc", {8'h0, now()}, 32'h060001);

      // Reach 12:34:56, then asynchronous reset mid-cycle
      set_mode = 1'b1;
      hold_hr(6);
      hold_min(34);
      set_mode = 1'b0;
      @(negedge clk);
      repeat (56) edge_1hz(1'b1);
      check("run_123456", {8'h0, now()}, 32'h123456);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("async_rst", {8'h0, now()}, 32'h000000);
      repeat (3) @(negedge clk);
      check("rst_hold", {7'h0, sec_tick, now()}, 32'h000000);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/time_counter.md
Name: time_counter

Overview:
- Timekeeping core of the 24-hour clock. Sits directly downstream of the 1 Hz divider.
- Synchronises the divider's 1 Hz square wave into the system clock domain and detects its rising edge.
- Maintains hours, minutes and seconds as packed BCD, with a set mode for manual adjustment.
- Feeds the display/segment driver stage.

Parameters:
SYNC_STAGES, 2, number of flip-flops in the synchroniser on clk_1Hz_in (legal range 2..4)

Ports:
clk  in  1  system clock; all state updates on its rising edge
rst  in  1  asynchronous, active-high reset
clk_1Hz_in  in  1  1 Hz square wave from the divider, treated as asynchronous
set_mode  in  1  level; high = adjust mode
inc_hr  in  1  single-cycle pulse; increment hours (set mode only)
inc_min  in  1  single-cycle pulse; increment minutes (set mode only)
sec_bcd  out  8  seconds, BCD, [7:4] tens, [3:0] units, range 00..59
min_bcd  out  8  minutes, BCD, range 00..59
hr_bcd  out  8  hours, BCD, range 00..23
sec_tick  out  1  one-cycle pulse, high in the same cycle the new seconds value first appears

Behaviour:
- Reset: asynchronous, active-high.
  - Forces sec_bcd, min_bcd and hr_bcd to 8'h00, sec_tick to 0, all synchroniser flops to 0, and armed to 0.
  - Takes effect immediately, including mid-increment.
  - Release is sampled on the next rising edge of clk.
- Synchroniser and edge detector:
  - s = last synchroniser stage; s_d = s delayed by one cycle.
  - armed is set on the first cycle where s == 0.
  - rise = armed & s & ~s_d.
  - A high clk_1Hz_in at reset release produces no tick until it has been seen low once.
- Latency: input rising edge → counter update and sec_tick are registered SYNC_STAGES+1 cycles later, ±1 cycle of synchroniser uncertainty.
- Run mode (set_mode = 0), applied on a cycle where rise is true:
  - Seconds increment.
  - At 59, seconds wrap to 00 and minutes increment.
  - At minute 59, minutes wrap to 00 and hours increment.
  - At hour 23, hours wrap to 00.
  - Full rollover: 23:59:59 → 00:00:00 in one cycle.
  - sec_tick is asserted for exactly that cycle.
  - inc_hr and inc_min are ignored.
- Set mode (set_mode = 1):
  - Rising edge of set_mode clears seconds to 00 on the next cycle.
  - Seconds stay 00 while in set mode. Ticks are discarded, not queued, and sec_tick stays 0.
  - inc_min: minutes +1, 59 → 00, no carry into hours.
  - inc_hr: hours +1, 23 → 00.
  - inc_hr and inc_min in the same cycle both apply.
  - A pulse held high for N cycles increments N times; debouncing is upstream.
- Leaving set mode: counting resumes from the set value at the next rise.
- BCD arithmetic: units digit wraps 9 → 0 with a carry into tens. Values above the maximum are unreachable; no illegal-code recovery is required.

Decomposition:
- Shared package clock_pkg:
  - SEC_MAX_BCD = 8'h59
  - MIN_MAX_BCD = 8'h59
  - HR_MAX_BCD = 8'h23
  - BCD_ZERO = 8'h00
- Sub-module bcd_mod_counter, instantiated three times:
  - Parameter MAX_BCD.
  - Inputs: clk, rst (asynchronous, active-high), clr, inc.
  - Outputs: 8-bit value, and combinational wrap = inc & (value == MAX_BCD).
  - Carry chain: seconds wrap → minutes inc, and minutes wrap → hours inc, in run mode only.

Test Plan:
- Reset release with clk_1Hz_in held low, then 60 input rising edges → time 00:01:00. sec_tick pulses exactly 60 times, each one cycle wide, SYNC_STAGES+1 (±1) cycles after its edge.
- Reset released while clk_1Hz_in = 1 → no tick and 00:00:00 until the input goes low; the next rising edge gives 00:00:01.
- set_mode = 1, 23 × inc_hr, 59 × inc_min, set_mode = 0, then 59 edges → 23:59:59; one more edge → 00:00:00 in a single cycle.
- In set mode with time 05:10:xx, apply 3 input edges and a simultaneous inc_hr + inc_min → 06:11:00 and no sec_tick. inc_min at minute 59 → 00 with hours unchanged.
- Assert rst asynchronously (mid-cycle, between clock edges) at 12:34:56 → all outputs read 00:00:00 before the next clk edge and stay there while rst is high.
- In run mode, pulse inc_hr and inc_min → time unchanged.
